// File: rtl/axi_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_mon_pkg
// Brief    : Shared definitions for the AXI protocol monitor: error index
//            enumeration, error count and address/size helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package axi_mon_pkg;

    localparam int ERR_N = 16;

    // Bit positions of err_sticky; also the values reported on first_err
    typedef enum logic [3:0] {
        ERR_AW_STAB = 4'd0,
        ERR_W_STAB  = 4'd1,
        ERR_B_STAB  = 4'd2,
        ERR_AR_STAB = 4'd3,
        ERR_R_STAB  = 4'd4,
        ERR_AW_TO   = 4'd5,
        ERR_W_TO    = 4'd6,
        ERR_B_TO    = 4'd7,
        ERR_AR_TO   = 4'd8,
        ERR_R_TO    = 4'd9,
        ERR_AW_ALGN = 4'd10,
        ERR_AR_ALGN = 4'd11,
        ERR_B_UNEXP = 4'd12,
        ERR_R_UNEXP = 4'd13,
        ERR_WR_OVF  = 4'd14,
        ERR_RD_OVF  = 4'd15
    } err_idx_e;

    // Address is misaligned for the beat size, or the beat is wider than the bus.
    // Sizes top out at 128 bytes, so only the low 7 address bits matter.
    function automatic logic align_err(
        input logic [6:0]  addr_lo,
        input logic [2:0]  size,
        input int unsigned bus_bytes
    );
        logic [7:0] bytes;
        bytes     = 8'd1 << size;
        align_err = (|(addr_lo & 7'(bytes - 8'd1))) || (32'(bytes) > bus_bytes);
    endfunction

    // Lowest set index of an error vector (0 when the vector is empty)
    function automatic logic [3:0] lowest_idx(input logic [ERR_N-1:0] vec);
        lowest_idx = '0;
        for (int i = ERR_N - 1; i >= 0; i--) begin
            if (vec[i]) lowest_idx = 4'(i);
        end
    endfunction

endpackage : axi_mon_pkg
`default_nettype wire

// File: rtl/axi_chan_watch.sv
`default_nettype none
// ============================================================================
// Module   : axi_chan_watch
// Brief    : Watches one valid/ready channel for payload/valid instability
//            during a stall and for stalls lasting TIMEOUT cycles. Both error
//            outputs are combinational on the current inputs.
// Revision : 1.0 - initial release
// ============================================================================
module axi_chan_watch #(
    parameter int PAYLOAD_W = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_ready,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_stab_err,
    output logic                 o_timeout_err
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] c_stall_max  = STALL_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] c_stall_trip = STALL_W'(TIMEOUT - 1);

    logic                 r_prev_stall;
    logic [PAYLOAD_W-1:0] r_prev_payload;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic                 w_stall;

    assign w_stall = i_valid && !i_ready;

    // A stall last cycle obliges valid and payload to be held this cycle
    assign o_stab_err = r_prev_stall && (!i_valid || (i_payload != r_prev_payload));

    // Fires only on the edge where the counter steps onto TIMEOUT
    assign o_timeout_err = w_stall && (r_stall_cnt == c_stall_trip);

    // Remember the previous cycle's stall state and payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_stall   <= 1'b0;
            r_prev_payload <= '0;
        end else begin
            r_prev_stall   <= w_stall;
            r_prev_payload <= i_payload;
        end
    end

    // Saturating stall-length counter, cleared by handshake or idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_stall) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != c_stall_max) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

endmodule : axi_chan_watch
`default_nettype wire

// File: rtl/axi_proto_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi_proto_monitor
// Brief    : Passive AXI protocol checker. Flags handshake stability, stall
//            timeouts, address alignment, unexpected responses and
//            outstanding-transaction overflow into sticky/pulse status.
// Revision : 1.0 - initial release
// ============================================================================
module axi_proto_monitor
    import axi_mon_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 16,
    parameter  int MAX_OUT = 8,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic              aclk,
    input  logic              reset,
    // Write address
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [2:0]        awsize,
    // Write data
    input  logic              wvalid,
    input  logic              wready,
    input  logic              wlast,
    input  logic [DATA_W-1:0] wdata,
    // Write response
    input  logic              bvalid,
    input  logic              bready,
    input  logic [1:0]        bresp,
    // Read address
    input  logic              arvalid,
    input  logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [2:0]        arsize,
    // Read data
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    // Status
    input  logic              clr_err,
    output logic [ERR_N-1:0]  err_sticky,
    output logic              err_pulse,
    output logic              first_err_vld,
    output logic [3:0]        first_err,
    output logic [CNT_W-1:0]  wr_out,
    output logic [CNT_W-1:0]  rd_out
);

    localparam int          LO_W        = (ADDR_W < 7) ? ADDR_W : 7;
    localparam int unsigned c_bus_bytes = DATA_W / 8;
    localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUT);

    logic [4:0] w_stab;
    logic [4:0] w_to;

    logic w_aw_hs, w_b_hs, w_ar_hs, w_rl_hs;
    logic w_aw_algn, w_ar_algn;
    logic w_b_unexp, w_r_unexp, w_wr_ovf, w_rd_ovf;
    logic [CNT_W-1:0] w_wr_next, w_rd_next;
    logic [ERR_N-1:0] w_viol;

    logic [CNT_W-1:0] r_wr_out, r_rd_out;
    logic [ERR_N-1:0] r_viol;
    logic [ERR_N-1:0] r_sticky;
    logic             r_pulse;
    logic             r_first_vld;
    logic [3:0]       r_first;

    // ---------------------------------------------------------------- channels
    axi_chan_watch #(.PAYLOAD_W(ADDR_W + 3), .TIMEOUT(TIMEOUT)) u_aw_watch (
        .clk(aclk), .rst(reset), .i_valid(awvalid), .i_ready(awready),
        .i_payload({awaddr, awsize}),
        .o_stab_err(w_stab[0]), .o_timeout_err(w_to[0])
    );

    axi_chan_watch #(.PAYLOAD_W(DATA_W + 1), .TIMEOUT(TIMEOUT)) u_w_watch (
        .clk(aclk), .rst(reset), .i_valid(wvalid), .i_ready(wready),
        .i_payload({wdata, wlast}),
        .o_stab_err(w_stab[1]), .o_timeout_err(w_to[1])
    );

    axi_chan_watch #(.PAYLOAD_W(2), .TIMEOUT(TIMEOUT)) u_b_watch (
        .clk(aclk), .rst(reset), .i_valid(bvalid), .i_ready(bready),
        .i_payload(bresp),
        .o_stab_err(w_stab[2]), .o_timeout_err(w_to[2])
    );

    axi_chan_watch #(.PAYLOAD_W(ADDR_W + 3), .TIMEOUT(TIMEOUT)) u_ar_watch (
        .clk(aclk), .rst(reset), .i_valid(arvalid), .i_ready(arready),
        .i_payload({araddr, arsize}),
        .o_stab_err(w_stab[3]), .o_timeout_err(w_to[3])
    );

    axi_chan_watch #(.PAYLOAD_W(DATA_W + 3), .TIMEOUT(TIMEOUT)) u_r_watch (
        .clk(aclk), .rst(reset), .i_valid(rvalid), .i_ready(rready),
        .i_payload({rdata, rresp, rlast}),
        .o_stab_err(w_stab[4]), .o_timeout_err(w_to[4])
    );

    // ------------------------------------------------------------- handshakes
    assign w_aw_hs = awvalid && awready;
    assign w_b_hs  = bvalid && bready;
    assign w_ar_hs = arvalid && arready;
    assign w_rl_hs = rvalid && rready && rlast;

    assign w_aw_algn = w_aw_hs && align_err(7'(awaddr[LO_W-1:0]), awsize, c_bus_bytes);
    assign w_ar_algn = w_ar_hs && align_err(7'(araddr[LO_W-1:0]), arsize, c_bus_bytes);

    // Write outstanding tracking: an unmatched B underflows, an AW at the limit overflows
    always_comb begin
        w_wr_next = r_wr_out;
        w_b_unexp = 1'b0;
        w_wr_ovf  = 1'b0;
        case ({w_aw_hs, w_b_hs})
            2'b10: begin
                if (r_wr_out == c_max_out) w_wr_ovf  = 1'b1;
                else                       w_wr_next = r_wr_out + CNT_W'(1);
            end
            2'b01: begin
                if (r_wr_out == '0) w_b_unexp = 1'b1;
                else                w_wr_next = r_wr_out - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Read outstanding tracking: a burst completes on its last R beat
    always_comb begin
        w_rd_next = r_rd_out;
        w_r_unexp = 1'b0;
        w_rd_ovf  = 1'b0;
        case ({w_ar_hs, w_rl_hs})
            2'b10: begin
                if (r_rd_out == c_max_out) w_rd_ovf  = 1'b1;
                else                       w_rd_next = r_rd_out + CNT_W'(1);
            end
            2'b01: begin
                if (r_rd_out == '0) w_r_unexp = 1'b1;
                else                w_rd_next = r_rd_out - CNT_W'(1);
            end
            default: ;
        endcase
    end

    assign w_viol = {w_rd_ovf, w_wr_ovf, w_r_unexp, w_b_unexp,
                     w_ar_algn, w_aw_algn, w_to, w_stab};

    // Outstanding counters
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wr_out <= '0;
            r_rd_out <= '0;
        end else begin
            r_wr_out <= w_wr_next;
            r_rd_out <= w_rd_next;
        end
    end

    // Violations are staged once before reaching the status outputs
    always_ff @(posedge aclk) begin
        if (reset) r_viol <= '0;
        else       r_viol <= w_viol;
    end

    // Status: clear takes effect first so a coincident violation survives
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_sticky    <= '0;
            r_pulse     <= 1'b0;
            r_first_vld <= 1'b0;
            r_first     <= '0;
        end else begin
            r_sticky <= (clr_err ? '0 : r_sticky) | r_viol;
            r_pulse  <= |r_viol;
            if ((|r_viol) && (clr_err || !r_first_vld)) begin
                r_first_vld <= 1'b1;
                r_first     <= lowest_idx(r_viol);
            end else if (clr_err) begin
                r_first_vld <= 1'b0;
                r_first     <= '0;
            end
        end
    end

    assign err_sticky    = r_sticky;
    assign err_pulse     = r_pulse;
    assign first_err_vld = r_first_vld;
    assign first_err     = r_first;
    assign wr_out        = r_wr_out;
    assign rd_out        = r_rd_out;

endmodule : axi_proto_monitor
`default_nettype wire
